hub75_scan_sequencer: RTL



---
 rtl/hub75_scan_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hub75_scan_sequencer.sv
// HUB75 panel scan sequencer: fetch, shift, latch and display each row pair, then advance,
// with a tear-free front/back bank swap at frame end. Optional macro SCAN_BCM_EN adds 3 bit-planes per row.
module hub75_scan_sequencer #(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 4,
    parameter int DWELL    = 27
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 swap_req,
    output logic                                 swap_ack,
    output logic                                 bank,
    output logic                                 rd_en,
    output logic [ROW_BITS-1:0]                  radr,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col,
    output logic                                 matrixclk,
    output logic                                 LAT,
    output logic                                 BLANK,
    output logic [ROW_BITS-1:0]                  row,
    output logic                                 frame_start,
    output logic [1:0]                           plane
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(DWELL * 4 + 1);
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        DISPLAY,
        ADVANCE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dwell_last;

`ifdef SCAN_BCM_EN
    // Binary-weighted display time: plane n is shown for DWELL << n cycles.
    always_comb begin
        dwell_last = CNT_W'((DWELL << plane) - 1);
    end
`else
    always_comb begin
        dwell_last = CNT_W'(DWELL - 1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            BLANK       <= 1'b1;
            LAT         <= 1'b0;
            matrixclk   <= 1'b0;
            row         <= '0;
            radr        <= '0;
            col         <= '0;
            bank        <= 1'b0;
            plane       <= 2'd0;
            rd_en       <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            LAT         <= 1'b0;
            case (state)
                IDLE: begin
                    BLANK     <= 1'b1;
                    matrixclk <= 1'b0;
                    if (en) begin
                        state       <= FETCH;
                        cnt         <= '0;
                        rd_en       <= 1'b1;
                        frame_start <= (radr == '0);
                    end
                end
                FETCH: begin
                    // Second cycle absorbs RAM latency plus the pixel register.
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        col       <= '0;
                        matrixclk <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!matrixclk) begin
                        matrixclk <= 1'b1;
                    end else begin
                        matrixclk <= 1'b0;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            state <= LATCH;
                            LAT   <= 1'b1;
                            row   <= radr;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    state <= DISPLAY;
                    BLANK <= 1'b0;
                    cnt   <= '0;
                end
                DISPLAY: begin
                    if (cnt == dwell_last) begin
                        BLANK <= 1'b1;
                        cnt   <= '0;
`ifdef SCAN_BCM_EN
                        if (plane != 2'd2) begin
                            plane <= plane + 2'd1;
                            state <= FETCH;
                            rd_en <= 1'b1;
                        end else begin
                            plane <= 2'd0;
                            state <= ADVANCE;
                            if (radr == ROW_LAST && swap_req) begin
                                bank     <= ~bank;
                                swap_ack <= 1'b1;
                            end
                        end
`else
                        state <= ADVANCE;
                        // Swap only once the last row of the frame has been shown.
                        if (radr == ROW_LAST && swap_req) begin
                            bank     <= ~bank;
                            swap_ack <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADVANCE: begin
                    BLANK <= 1'b1;
                    radr  <= radr + 1'b1;
                    cnt   <= '0;
                    if (en) begin
                        state       <= FETCH;
                        rd_en       <= 1'b1;
                        frame_start <= (radr == ROW_LAST);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BLANK <= 1'b1;
                end
            endcase
        end
    end

endmodule
